// File: rtl/approx_fp_mul_pipe.sv
// rtl/approx_fp_mul_pipe.sv - pipelined approximate FP multiplier (3 stages, RNE, valid/ready)
// Define APPROX_FP_MUL_EXACT_EN to use full-width significands (correctly rounded product).
module approx_fp_mul_pipe #(
   parameter int EW   = 8,
   parameter int MW   = 23,
   parameter int KEEP = 12
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [EW+MW:0]   a,
   input  logic [EW+MW:0]   b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [EW+MW:0]   y,
   output logic             ovf,
   output logic             unf
);

`ifdef APPROX_FP_MUL_EXACT_EN
   localparam int K = MW;
`else
   localparam int K = KEEP;
`endif
   localparam int N   = 1 + EW + MW;
   localparam int SW  = K + 1;
   localparam int PW  = 2 * K + 2;
   localparam int FW  = 2 * K + 1;
   localparam int EXW = EW + 2;

   localparam logic [EXW-1:0] BIAS = EXW'((1 << (EW - 1)) - 1);
   localparam logic [EXW-1:0] EMAX = EXW'((1 << EW) - 1);
   localparam logic [EW-1:0]  EXP_ONES = '1;
   localparam logic [N-1:0]   QNAN = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};

   localparam logic [1:0] C_NORM = 2'd0;
   localparam logic [1:0] C_ZERO = 2'd1;
   localparam logic [1:0] C_INF  = 2'd2;
   localparam logic [1:0] C_NAN  = 2'd3;

   logic adv;

   // ---------------- unpack and classify ----------------
   logic          a_sign, b_sign;
   logic [EW-1:0] a_exp, b_exp;
   logic [MW-1:0] a_frac, b_frac;
   logic          a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
   logic [1:0]    cls_d;

   assign a_sign = a[N-1];
   assign b_sign = b[N-1];
   assign a_exp  = a[N-2 -: EW];
   assign b_exp  = b[N-2 -: EW];
   assign a_frac = a[MW-1:0];
   assign b_frac = b[MW-1:0];

   assign a_nan  = (a_exp == EXP_ONES) && (a_frac != '0);
   assign b_nan  = (b_exp == EXP_ONES) && (b_frac != '0);
   assign a_inf  = (a_exp == EXP_ONES) && (a_frac == '0);
   assign b_inf  = (b_exp == EXP_ONES) && (b_frac == '0);
   assign a_zero = (a_exp == '0);
   assign b_zero = (b_exp == '0);

   // Denormals count as zero here, so inf*denormal is also NaN.
   always_comb begin
      cls_d = C_NORM;
      if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
         cls_d = C_NAN;
      else if (a_inf || b_inf)
         cls_d = C_INF;
      else if (a_zero || b_zero)
         cls_d = C_ZERO;
   end

   // ---------------- stage 1 registers ----------------
   logic          s1_valid_q, s1_sign_q;
   logic [1:0]    s1_cls_q;
   logic [EW-1:0] s1_ea_q, s1_eb_q;
   logic [SW-1:0] s1_sa_q, s1_sb_q;
   logic [SW-1:0] sa_d, sb_d;

   assign sa_d = {1'b1, a_frac[MW-1 -: K]};
   assign sb_d = {1'b1, b_frac[MW-1 -: K]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_sign_q  <= 1'b0;
         s1_cls_q   <= C_NORM;
         s1_ea_q    <= '0;
         s1_eb_q    <= '0;
         s1_sa_q    <= '0;
         s1_sb_q    <= '0;
      end else if (adv) begin
         s1_valid_q <= in_valid;
         s1_sign_q  <= a_sign ^ b_sign;
         s1_cls_q   <= cls_d;
         s1_ea_q    <= a_exp;
         s1_eb_q    <= b_exp;
         s1_sa_q    <= sa_d;
         s1_sb_q    <= sb_d;
      end
   end

   // ---------------- stage 2: significand multiply ----------------
   logic           s2_valid_q, s2_sign_q;
   logic [1:0]     s2_cls_q;
   logic [EXW-1:0] s2_esum_q, s2_esum_d;
   logic [PW-1:0]  s2_p_q, s2_p_d;

   assign s2_p_d    = PW'(s1_sa_q) * PW'(s1_sb_q);
   assign s2_esum_d = EXW'(s1_ea_q) + EXW'(s1_eb_q) - BIAS;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_valid_q <= 1'b0;
         s2_sign_q  <= 1'b0;
         s2_cls_q   <= C_NORM;
         s2_esum_q  <= '0;
         s2_p_q     <= '0;
      end else if (adv) begin
         s2_valid_q <= s1_valid_q;
         s2_sign_q  <= s1_sign_q;
         s2_cls_q   <= s1_cls_q;
         s2_esum_q  <= s2_esum_d;
         s2_p_q     <= s2_p_d;
      end
   end

   // ---------------- stage 3: normalise, round, pack ----------------
   logic          norm;
   logic [FW-1:0] f;
   logic [MW-1:0] frac_r;
   logic          rc;

   assign norm = s2_p_q[PW-1];
   assign f    = norm ? s2_p_q[FW-1:0] : {s2_p_q[FW-2:0], 1'b0};

   generate
      if (FW > MW) begin : g_round
         logic [MW-1:0] frac_t;
         logic [MW:0]   rnd;
         logic          g_bit, st_bit, inc;
         assign frac_t = f[FW-1 -: MW];
         assign g_bit  = f[FW-1-MW];
         if (FW - 1 - MW > 0) begin : g_sticky
            assign st_bit = |f[FW-2-MW:0];
         end else begin : g_nosticky
            assign st_bit = 1'b0;
         end
         assign inc    = g_bit && (frac_t[0] || st_bit);
         assign rnd    = {1'b0, frac_t} + (MW+1)'(inc);
         assign frac_r = rnd[MW-1:0];
         assign rc     = rnd[MW];
      end else begin : g_pad
         assign frac_r = MW'(f) << (MW - FW);
         assign rc     = 1'b0;
      end
   endgenerate

   logic [EXW-1:0] e_fin;
   logic [N-1:0]   y_d, y_q;
   logic           ovf_d, unf_d, ovf_q, unf_q, out_valid_q;

   assign e_fin = s2_esum_q + EXW'(norm) + EXW'(rc);

   always_comb begin
      y_d   = '0;
      ovf_d = 1'b0;
      unf_d = 1'b0;
      case (s2_cls_q)
         C_NAN:  y_d = QNAN;
         C_INF:  y_d = {s2_sign_q, EXP_ONES, {MW{1'b0}}};
         C_ZERO: y_d = {s2_sign_q, {EW{1'b0}}, {MW{1'b0}}};
         default: begin
            if ($signed(e_fin) >= $signed(EMAX)) begin
               y_d   = {s2_sign_q, EXP_ONES, {MW{1'b0}}};
               ovf_d = 1'b1;
            end else if ($signed(e_fin) <= $signed(EXW'(0))) begin
               y_d   = {s2_sign_q, {EW{1'b0}}, {MW{1'b0}}};
               unf_d = 1'b1;
            end else begin
               y_d   = {s2_sign_q, e_fin[EW-1:0], frac_r};
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         y_q         <= '0;
         ovf_q       <= 1'b0;
         unf_q       <= 1'b0;
      end else if (adv) begin
         out_valid_q <= s2_valid_q;
         y_q         <= y_d;
         ovf_q       <= ovf_d;
         unf_q       <= unf_d;
      end
   end

   // One enable for the whole pipe: everything moves only when the output slot frees.
   assign adv       = !out_valid_q || out_ready;
   assign in_ready  = adv;
   assign out_valid = out_valid_q;
   assign y         = y_q;
   assign ovf       = ovf_q;
   assign unf       = unf_q;

endmodule

// File: tb/tb_approx_fp_mul_pipe.sv
// tb/tb_approx_fp_mul_pipe.sv - directed self-checking bench for approx_fp_mul_pipe (default params)
module tb_approx_fp_mul_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a, b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] y;
   logic        ovf, unf;

   int checks   = 0;
   int failures = 0;

`ifdef APPROX_FP_MUL_EXACT_EN
   localparam logic [31:0] TRUNC_EXP = 32'h3F800001;
`else
   localparam logic [31:0] TRUNC_EXP = 32'h3F800000;
`endif

   always #5 clk = ~clk;

   approx_fp_mul_pipe dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .y         (y),
      .ovf       (ovf),
      .unf       (unf)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_op(input string tag, input logic [31:0] xa, input logic [31:0] xb,
                         input logic [31:0] ey, input logic eo, input logic eu);
      a = xa;
      b = xb;
      in_valid = 1'b1;
      #1;
      check({tag, ".in_ready"}, in_ready, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check({tag, ".lat1"}, out_valid, 0);
      tick();
      check({tag, ".lat2"}, out_valid, 0);
      tick();
      check({tag, ".valid"}, out_valid, 1);
      check({tag, ".y"}, y, ey);
      check({tag, ".ovf"}, ovf, eo);
      check({tag, ".unf"}, unf, eu);
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit expired");
      $fatal(1, "watchdog");
   end

   logic [31:0] bp_a [4];
   logic [31:0] bp_b [4];
   logic [31:0] bp_y [4];
   logic [31:0] got [$];
   logic [31:0] held;
   int          idx;

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      a         = '0;
      b         = '0;
      held      = '0;
      #1;
      check("reset.out_valid", out_valid, 0);
      check("reset.y", y, 0);
      check("reset.ovf", ovf, 0);
      check("reset.unf", unf, 0);
      check("reset.in_ready", in_ready, 1);
      tick();
      tick();
      rst = 1'b0;
      tick();

      run_op("mul_1p5x2",   32'h3FC00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0);
      run_op("mul_m3xhalf", 32'hC0400000, 32'h3F000000, 32'hBFC00000, 1'b0, 1'b0);
      run_op("overflow",    32'h7F000000, 32'h7F000000, 32'h7F800000, 1'b1, 1'b0);
      run_op("underflow",   32'h00800000, 32'h00800000, 32'h00000000, 1'b0, 1'b1);
      run_op("zero_x_inf",  32'h00000000, 32'h7F800000, 32'h7FC00000, 1'b0, 1'b0);
      run_op("inf_x_neg1",  32'h7F800000, 32'hBF800000, 32'hFF800000, 1'b0, 1'b0);
      run_op("nan_in",      32'h7F800001, 32'h3F800000, 32'h7FC00000, 1'b0, 1'b0);
      run_op("truncation",  32'h3F800001, 32'h3F800000, TRUNC_EXP,    1'b0, 1'b0);
      run_op("rne_tie",     32'h3F800800, 32'h3F800800, 32'h3F801000, 1'b0, 1'b0);
      run_op("rne_up",      32'h3F801800, 32'h3F800800, 32'h3F802002, 1'b0, 1'b0);

      bp_a[0] = 32'h3FC00000; bp_b[0] = 32'h40000000; bp_y[0] = 32'h40400000;
      bp_a[1] = 32'hC0400000; bp_b[1] = 32'h3F000000; bp_y[1] = 32'hBFC00000;
      bp_a[2] = 32'h40000000; bp_b[2] = 32'h40000000; bp_y[2] = 32'h40800000;
      bp_a[3] = 32'h3F800000; bp_b[3] = 32'h3F800000; bp_y[3] = 32'h3F800000;
      idx = 0;
      for (int t = 0; t < 24; t++) begin
         out_ready = !(t >= 4 && t < 9);
         if (idx < 4) begin
            a = bp_a[idx];
            b = bp_b[idx];
            in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         #1;
         if (!out_ready) begin
            check("bp.in_ready_low", in_ready, 0);
            check("bp.out_valid_held", out_valid, 1);
            if (t == 4) held = y;
            else check("bp.y_stable", y, held);
         end
         if (out_valid && out_ready) got.push_back(y);
         if (in_valid && in_ready) idx++;
         @(posedge clk);
         #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      check("bp.count", got.size(), 4);
      for (int i = 0; i < 4; i++) begin
         if (i < got.size()) check($sformatf("bp.order%0d", i), got[i], bp_y[i]);
      end

      for (int i = 0; i < 3; i++) begin
         a = bp_a[i];
         b = bp_b[i];
         in_valid = 1'b1;
         tick();
      end
      in_valid = 1'b0;
      check("rst.pre_out_valid", out_valid, 1);
      rst = 1'b1;
      #1;
      check("rst.async_out_valid", out_valid, 0);
      check("rst.async_y", y, 0);
      tick();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         check($sformatf("rst.no_stale%0d", i), out_valid, 0);
      end
      run_op("post_reset", 32'hC0400000, 32'h3F000000, 32'hBFC00000, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
